// File: rtl/crc_check.sv
// ============================================================================
// Module      : crc_check
// Description : Serial CRC frame checker. Shifts message plus check bits
//               through a remainder register, MSB first, and reports a
//               registered pass/fail verdict one cycle after the last bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_check #(
  parameter int                  CRC_LEN        = 16,
  parameter logic [CRC_LEN-1:0]  CRC_POLYNOMIAL = 16'h8005,
  parameter int                  CNT_W          = 16
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               data_in,
  input  logic               data_valid,
  input  logic               frame_last,
  input  logic               frame_abort,
  output logic               in_ready,
  output logic [CRC_LEN-1:0] crc_out,
  output logic [CNT_W-1:0]   bit_count,
  output logic               frame_done,
  output logic               crc_ok,
  output logic               crc_err,
  output logic               len_err
);

  // Frames no longer than the check field cannot carry a message.
  localparam logic [CNT_W-1:0] c_len = CNT_W'(CRC_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rdy_en;
  logic [CRC_LEN-1:0]   r_crc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ok;
  logic                 r_err;
  logic                 r_len;

  logic                 w_accept;
  logic                 w_abort;
  logic                 w_take;
  logic                 w_last;
  logic [CRC_LEN-1:0]   w_crc_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  // A handshake with abort in RECV is swallowed: abort wins and the bit is dropped.
  assign w_accept = data_valid && in_ready;
  assign w_abort  = frame_abort && (r_state == RECV);
  assign w_take   = w_accept && !w_abort;
  assign w_last   = w_take && frame_last;

  // Remainder and length as they will be after the current bit is taken.
  // In IDLE the remainder is already zero, so the same shift applies.
  assign w_crc_nxt = {r_crc[CRC_LEN-2:0], data_in}
                   ^ (CRC_POLYNOMIAL & {CRC_LEN{r_crc[CRC_LEN-1]}});
  assign w_cnt_nxt = (r_state == IDLE) ? CNT_W'(1)
                   : ((r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1));

  // State register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = r_rdy_en;
        if (w_take) begin
          w_state_nxt = frame_last ? DONE : RECV;
        end
      end
      RECV: begin
        in_ready = r_rdy_en;
        if (w_abort) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  // Remainder and bit counter; cleared when leaving DONE or on abort.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= '0;
      r_cnt <= '0;
    end else if ((r_state == DONE) || w_abort) begin
      r_crc <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_crc <= w_crc_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Verdict registered on the edge that accepts the last bit, held until the next one.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
      r_len <= 1'b0;
    end else if (w_last) begin
      r_err <= (w_crc_nxt != '0);
      r_len <= (w_cnt_nxt <= c_len);
      r_ok  <= (w_crc_nxt == '0) && (w_cnt_nxt > c_len);
    end
  end

  assign crc_out   = r_crc;
  assign bit_count = r_cnt;
  assign crc_ok    = r_ok;
  assign crc_err   = r_err;
  assign len_err   = r_len;

endmodule

`default_nettype wire

// File: tb/tb_crc_check.sv
// ============================================================================
// Module      : tb_crc_check
// Description : Directed, table-driven bench for crc_check (CRC-16 0x8005).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_check;

  logic        clk_in;
  logic        reset_n;
  logic        data_in;
  logic        data_valid;
  logic        frame_last;
  logic        frame_abort;
  logic        in_ready;
  logic [15:0] crc_out;
  logic [15:0] bit_count;
  logic        frame_done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;

  int n_checks = 0;
  int n_errors = 0;

  // Expected held status, updated whenever a frame completes.
  logic e_ok, e_err, e_len;

  typedef struct {
    logic [16:0] bits;
    int          n;
    logic [15:0] crc;
    int          cnt;
    logic        ok;
    logic        err;
    logic        len;
  } vec_t;

  vec_t tbl[6];

  crc_check #(
    .CRC_LEN        (16),
    .CRC_POLYNOMIAL (16'h8005),
    .CNT_W          (16)
  ) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .frame_last  (frame_last),
    .frame_abort (frame_abort),
    .in_ready    (in_ready),
    .crc_out     (crc_out),
    .bit_count   (bit_count),
    .frame_done  (frame_done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .len_err     (len_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, sample 2ns later.
  task automatic step(input logic v, input logic d, input logic l, input logic a);
    @(negedge clk_in);
    data_valid  = v;
    data_in     = d;
    frame_last  = l;
    frame_abort = a;
    @(posedge clk_in);
    #2;
  endtask

  task automatic check_status(input string nm);
    chk({nm, ".crc_ok"},  32'(crc_ok),  32'(e_ok));
    chk({nm, ".crc_err"}, 32'(crc_err), 32'(e_err));
    chk({nm, ".len_err"}, 32'(len_err), 32'(e_len));
  endtask

  // Sends a frame MSB first, optionally with a 3-cycle gap, checks the DONE
  // cycle and the following cycle (during which data_valid = post_dv).
  task automatic run_frame(input string nm, input logic [16:0] bits, input int n,
                           input int gap_after, input logic [15:0] ecrc, input int ecnt,
                           input logic eok, input logic eerr, input logic elen,
                           input logic post_dv);
    for (int i = 0; i < n; i++) begin
      if (i == gap_after) begin
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      step(1'b1, bits[n-1-i], (i == n-1), 1'b0);
    end
    e_ok  = eok;
    e_err = eerr;
    e_len = elen;
    chk({nm, ".frame_done"}, 32'(frame_done), 32'd1);
    chk({nm, ".in_ready_done"}, 32'(in_ready), 32'd0);
    chk({nm, ".crc_out"}, 32'(crc_out), 32'(ecrc));
    chk({nm, ".bit_count"}, 32'(bit_count), 32'(ecnt));
    check_status(nm);
    step(post_dv, 1'b1, 1'b0, 1'b0);
    chk({nm, ".frame_done_after"}, 32'(frame_done), 32'd0);
    chk({nm, ".in_ready_after"}, 32'(in_ready), 32'd1);
    chk({nm, ".crc_cleared"}, 32'(crc_out), 32'd0);
    chk({nm, ".count_cleared"}, 32'(bit_count), 32'd0);
    check_status({nm, "_held"});
  endtask

  initial begin
    // Good frame: message "1" followed by its check value 0x8005.
    tbl[0] = '{bits: 17'h18005, n: 17, crc: 16'h0000, cnt: 17, ok: 1'b1, err: 1'b0, len: 1'b0};
    // Same with the final bit flipped.
    tbl[1] = '{bits: 17'h18004, n: 17, crc: 16'h0001, cnt: 17, ok: 1'b0, err: 1'b1, len: 1'b0};
    // 16 zeros: clean remainder but too short.
    tbl[2] = '{bits: 17'h00000, n: 16, crc: 16'h0000, cnt: 16, ok: 1'b0, err: 1'b0, len: 1'b1};
    // 17 zeros: shortest passing length.
    tbl[3] = '{bits: 17'h00000, n: 17, crc: 16'h0000, cnt: 17, ok: 1'b1, err: 1'b0, len: 1'b0};
    // Single bit flagged last straight from IDLE.
    tbl[4] = '{bits: 17'h00001, n: 1,  crc: 16'h0001, cnt: 1,  ok: 1'b0, err: 1'b1, len: 1'b1};
    // 1 then 16 zeros: MSB falls out on the last bit, remainder becomes the polynomial.
    tbl[5] = '{bits: 17'h10000, n: 17, crc: 16'h8005, cnt: 17, ok: 1'b0, err: 1'b1, len: 1'b0};

    reset_n     = 1'b0;
    data_in     = 1'b0;
    data_valid  = 1'b0;
    frame_last  = 1'b0;
    frame_abort = 1'b0;
    e_ok = 1'b0; e_err = 1'b0; e_len = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk_in);
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.crc_out", 32'(crc_out), 32'd0);
    chk("rst.bit_count", 32'(bit_count), 32'd0);
    chk("rst.frame_done", 32'(frame_done), 32'd0);
    check_status("rst");
    @(negedge clk_in);
    reset_n = 1'b1;
    #1;
    chk("rel.in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk_in);
    #2;
    chk("rel.in_ready_after_edge", 32'(in_ready), 32'd1);

    // Table-driven frames.
    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("vec%0d", k), tbl[k].bits, tbl[k].n, -1, tbl[k].crc,
                tbl[k].cnt, tbl[k].ok, tbl[k].err, tbl[k].len, 1'b0);
    end

    // Abort after 8 bits of the good frame, with a simultaneous valid bit.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[0].bits[16-i], 1'b0, 1'b0);
    end
    chk("abort.crc_before", 32'(crc_out), 32'h00C0);
    chk("abort.count_before", 32'(bit_count), 32'd8);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("abort.frame_done", 32'(frame_done), 32'd0);
    chk("abort.crc_out", 32'(crc_out), 32'd0);
    chk("abort.bit_count", 32'(bit_count), 32'd0);
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    check_status("abort");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.frame_done_next", 32'(frame_done), 32'd0);

    // Abort in IDLE has no effect: the bit still starts a frame.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_idle.bit_count", 32'(bit_count), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("abort_recv.bit_count", 32'(bit_count), 32'd0);

    // Good frame with a 3-cycle valid gap after bit 8.
    run_frame("gap", tbl[0].bits, 17, 8, 16'h0000, 17, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back: corrupted frame, a bit offered in DONE (ignored), then good frame.
    run_frame("b2b_a", tbl[1].bits, 17, -1, 16'h0001, 17, 1'b0, 1'b1, 1'b0, 1'b1);
    run_frame("b2b_b", tbl[0].bits, 17, -1, 16'h0000, 17, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame after 10 bits of the corrupted frame.
    run_frame("pre_rst", tbl[1].bits, 17, -1, 16'h0001, 17, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tbl[0].bits[16-i], 1'b0, 1'b0);
    end
    chk("midrst.crc_before", 32'(crc_out), 32'h0300);
    chk("midrst.count_before", 32'(bit_count), 32'd10);
    @(negedge clk_in);
    data_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    e_ok = 1'b0; e_err = 1'b0; e_len = 1'b0;
    chk("midrst.crc_out", 32'(crc_out), 32'd0);
    chk("midrst.bit_count", 32'(bit_count), 32'd0);
    chk("midrst.frame_done", 32'(frame_done), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    check_status("midrst");
    @(negedge clk_in);
    reset_n = 1'b1;
    @(posedge clk_in);
    #2;
    chk("midrst.frame_done_after", 32'(frame_done), 32'd0);
    chk("midrst.in_ready_after", 32'(in_ready), 32'd1);
    run_frame("post_rst", tbl[0].bits, 17, -1, 16'h0000, 17, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
